// File: rtl/cmd_pkg.sv
// cmd_pkg: shared state encoding, command framing constants and response-type helpers for the SD command layer.
package cmd_pkg;
    localparam int RESP_W = 136;
    localparam int CMD_W  = 40;
    localparam logic [1:0] CMD_START_BITS = 2'b01;
    localparam logic [5:0] IDX_R2  = 6'd2;
    localparam logic [5:0] IDX_CSD = 6'd9;
    localparam logic [5:0] IDX_CID = 6'd10;
    localparam logic [5:0] IDX_R3  = 6'd41;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RESP,
        S_ACK,
        S_RETRY,
        S_DONE
    } state_t;

    // R2 and R3 responses carry no index echo, so they skip header validation
    function automatic logic is_long_resp(input logic [5:0] idx);
        return idx inside {IDX_R2, IDX_CSD, IDX_CID, IDX_R3};
    endfunction
endpackage

// File: rtl/cmd_layer_controller_if.sv
// cmd_layer_controller_if: host request/status and command PHY handshake bundle.
interface cmd_layer_controller_if;
    import cmd_pkg::*;
    logic              new_command;
    logic [5:0]        cmd_index;
    logic [31:0]       cmd_argument;
    logic              busy;
    logic              command_complete;
    logic [RESP_W-1:0] response_out;
    logic              cmd_error;
    logic              response_error;
    logic [CMD_W-1:0]  cmd_to_send;
    logic              phys_strobe;
    logic              phys_ack;
    logic              phys_idle;
    logic              timeout_enable;
    logic              phys_ack_out;
    logic              phys_strobe_out;
    logic [RESP_W-1:0] phys_response;
    logic              phys_timeout;

    modport master (
        input  new_command, cmd_index, cmd_argument,
        input  phys_ack_out, phys_strobe_out, phys_response, phys_timeout,
        output busy, command_complete, response_out, cmd_error, response_error,
        output cmd_to_send, phys_strobe, phys_ack, phys_idle, timeout_enable
    );

    modport slave (
        output new_command, cmd_index, cmd_argument,
        output phys_ack_out, phys_strobe_out, phys_response, phys_timeout,
        input  busy, command_complete, response_out, cmd_error, response_error,
        input  cmd_to_send, phys_strobe, phys_ack, phys_idle, timeout_enable
    );
endinterface

// File: rtl/cmd_watchdog_counter.sv
// cmd_watchdog_counter: saturating cycle counter that flags when LIMIT enabled cycles have elapsed.
module cmd_watchdog_counter #(
    parameter int LIMIT = 64,
    parameter int CW = $clog2(LIMIT + 1)
) (
    input  logic          sd_clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          enable,
    output logic          expired
);
    logic [CW-1:0] count;

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (load) count <= load_value;
        else if (enable && count != CW'(LIMIT)) count <= count + 1'b1;
    end

    // the current enabled cycle is the LIMIT-th one
    assign expired = enable && (count >= CW'(LIMIT - 1));
endmodule

// File: rtl/cmd_layer_controller.sv
// cmd_layer_controller: sequences one SD command through the PHY with ack watchdog, retries and response checks.
module cmd_layer_controller
    import cmd_pkg::*;
#(
    parameter int MAX_RETRIES = 2,
    parameter int ACK_TIMEOUT = 64,
    parameter int RETRY_W = 2
) (
    input logic sd_clock,
    input logic reset,
    cmd_layer_controller_if.master bus
);
    state_t state, state_n;
    logic [RETRY_W-1:0] retry;
    logic wd_expired;
    logic accept;
    logic can_retry;

    assign accept = state == S_IDLE && bus.new_command && !bus.busy;
    assign can_retry = retry < RETRY_W'(MAX_RETRIES);

    cmd_watchdog_counter #(.LIMIT(ACK_TIMEOUT)) u_watchdog (
        .sd_clock  (sd_clock),
        .reset     (reset),
        .clear     (state != S_SEND),
        .load      (1'b0),
        .load_value('0),
        .enable    (state == S_SEND),
        .expired   (wd_expired)
    );

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:      state_n = accept ? S_SEND : S_IDLE;
            S_SEND:      state_n = bus.phys_ack_out ? S_WAIT_RESP : (wd_expired ? S_RETRY : S_SEND);
            S_WAIT_RESP: state_n = bus.phys_strobe_out ? S_ACK : (bus.phys_timeout ? S_RETRY : S_WAIT_RESP);
            S_ACK:       state_n = S_DONE;
            S_RETRY:     state_n = can_retry ? S_SEND : S_DONE;
            S_DONE:      state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

    // handshake outputs follow the state one cycle later so every output is a flop
    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            bus.busy             <= 1'b0;
            bus.command_complete <= 1'b0;
            bus.response_out     <= '0;
            bus.cmd_error        <= 1'b0;
            bus.response_error   <= 1'b0;
            bus.cmd_to_send      <= '0;
            bus.phys_strobe      <= 1'b0;
            bus.phys_ack         <= 1'b0;
            bus.phys_idle        <= 1'b1;
            bus.timeout_enable   <= 1'b0;
            retry                <= '0;
        end else begin
            bus.busy             <= state != S_IDLE;
            bus.command_complete <= state == S_DONE;
            bus.phys_strobe      <= state == S_SEND;
            bus.phys_ack         <= state == S_ACK;
            bus.phys_idle        <= state inside {S_IDLE, S_RETRY, S_DONE};
            bus.timeout_enable   <= state inside {S_SEND, S_WAIT_RESP, S_ACK};
            if (accept) begin
                bus.cmd_to_send    <= {CMD_START_BITS, bus.cmd_index, bus.cmd_argument};
                bus.cmd_error      <= 1'b0;
                bus.response_error <= 1'b0;
                retry              <= '0;
            end
            if (state == S_WAIT_RESP && bus.phys_strobe_out) bus.response_out <= bus.phys_response;
            if (state == S_ACK && !is_long_resp(bus.cmd_to_send[37:32]) &&
                (bus.response_out[47:46] != 2'b00 || bus.response_out[45:40] != bus.cmd_to_send[37:32]))
                bus.response_error <= 1'b1;
            if (state == S_RETRY && can_retry) retry <= retry + 1'b1;
            if (state == S_RETRY && !can_retry) begin
                bus.cmd_error    <= 1'b1;
                bus.response_out <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cmd_layer_controller.sv
// tb_cmd_layer_controller: drives commands through an emulated PHY and checks outcomes against per-command expectations.
module tb_cmd_layer_controller;
    localparam int MAX_RETRIES = 2;
    localparam int ACK_TIMEOUT = 64;
    localparam int BUDGET = 600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    cmd_layer_controller_if bus();

    cmd_layer_controller #(.MAX_RETRIES(MAX_RETRIES), .ACK_TIMEOUT(ACK_TIMEOUT), .RETRY_W(2)) dut (
        .sd_clock(clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_complete"}, bus.command_complete, 0);
        chk({tag, "_resp"}, bus.response_out, 0);
        chk({tag, "_errs"}, {bus.cmd_error, bus.response_error}, 0);
        chk({tag, "_cmd"}, bus.cmd_to_send, 0);
        chk({tag, "_strobe_ack"}, {bus.phys_strobe, bus.phys_ack, bus.timeout_enable}, 0);
        chk({tag, "_idle"}, bus.phys_idle, 1);
    endtask

    // One command end to end: PHY fails the first 'fails' attempts with a timeout, then answers.
    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg, input int fails,
                           input bit never_ack, input bit both, input int ack_dly, input int resp_dly,
                           input logic [135:0] resp, input bit inject);
        int attempts = 0, idle_rises = 0, ack_cycles = 0, completes = 0, first_busy = 0, first_strobe = 0;
        int run = 0, run_min = 1000, run_max = 0, phase = 0, cnt = 0, after = 0;
        logic prev_s, prev_i, busy_after = 1'b1, got_ce = 1'b0, got_re = 1'b0, done = 1'b0;
        logic [39:0] got_cmd = '0;
        logic [135:0] got_resp = '0;
        bit err, long_resp, exp_re;
        @(negedge clk);
        bus.new_command = 1'b1;
        bus.cmd_index = idx;
        bus.cmd_argument = arg;
        prev_s = bus.phys_strobe;
        prev_i = bus.phys_idle;
        for (int cyc = 1; cyc <= BUDGET && !done; cyc++) begin
            @(negedge clk);
            bus.new_command = 1'b0;
            bus.phys_ack_out = 1'b0;
            bus.phys_strobe_out = 1'b0;
            bus.phys_timeout = 1'b0;
            bus.phys_response = ~resp;
            if (inject && cyc == 6) begin
                bus.new_command = 1'b1;
                bus.cmd_index = idx ^ 6'h3f;
                bus.cmd_argument = ~arg;
            end
            if (bus.busy && first_busy == 0) first_busy = cyc;
            if (bus.phys_strobe && first_strobe == 0) first_strobe = cyc;
            if (bus.phys_strobe && !prev_s) begin
                attempts++;
                phase = 1;
                cnt = ack_dly;
                run = 0;
            end
            if (bus.phys_strobe) run++;
            if (!bus.phys_strobe && prev_s) begin
                run_min = run < run_min ? run : run_min;
                run_max = run > run_max ? run : run_max;
            end
            if (bus.phys_idle && !prev_i) idle_rises++;
            if (bus.phys_ack) ack_cycles++;
            if (bus.command_complete) begin
                completes++;
                got_cmd = bus.cmd_to_send;
                got_ce = bus.cmd_error;
                got_re = bus.response_error;
                got_resp = bus.response_out;
            end
            if (completes > 0) after++;
            if (after == 2) busy_after = bus.busy;
            if (after == 3) done = 1'b1;
            if (phase == 1 && !never_ack) begin
                if (cnt == 0) begin
                    bus.phys_ack_out = 1'b1;
                    phase = 2;
                    cnt = resp_dly;
                end else cnt--;
            end else if (phase == 2) begin
                if (cnt == 0) begin
                    if (attempts <= fails) bus.phys_timeout = 1'b1;
                    else begin
                        bus.phys_strobe_out = 1'b1;
                        bus.phys_response = resp;
                        bus.phys_timeout = both;
                    end
                    phase = 0;
                end else cnt--;
            end
            prev_s = bus.phys_strobe;
            prev_i = bus.phys_idle;
        end
        bus.phys_ack_out = 1'b0;
        bus.phys_strobe_out = 1'b0;
        bus.phys_timeout = 1'b0;
        err = never_ack || fails > MAX_RETRIES;
        long_resp = idx inside {6'd2, 6'd9, 6'd10, 6'd41};
        exp_re = !err && !long_resp && (resp[47:46] != 2'b00 || resp[45:40] != idx);
        chk({tag, "_finished"}, done, 1);
        chk({tag, "_completes"}, completes, 1);
        chk({tag, "_cmd_to_send"}, got_cmd, {2'b01, idx, arg});
        chk({tag, "_cmd_error"}, got_ce, err);
        chk({tag, "_response_error"}, got_re, exp_re);
        chk({tag, "_response_out"}, got_resp, err ? 136'd0 : resp);
        chk({tag, "_attempts"}, attempts, err ? MAX_RETRIES + 1 : fails + 1);
        chk({tag, "_idle_pulses"}, idle_rises, err ? MAX_RETRIES + 1 : fails + 1);
        chk({tag, "_ack_cycles"}, ack_cycles, err ? 0 : 1);
        chk({tag, "_busy_latency"}, first_busy, 2);
        chk({tag, "_strobe_latency"}, first_strobe, 2);
        chk({tag, "_busy_drop"}, busy_after, 0);
        if (never_ack) begin
            chk({tag, "_strobe_run_min"}, run_min, ACK_TIMEOUT);
            chk({tag, "_strobe_run_max"}, run_max, ACK_TIMEOUT);
        end
    endtask

    initial begin
        logic [5:0] idx;
        logic [31:0] arg;
        logic [135:0] resp;
        logic [5:0] longs [4];
        int completes;
        bit seen;
        longs[0] = 6'd2; longs[1] = 6'd9; longs[2] = 6'd10; longs[3] = 6'd41;
        bus.new_command = 1'b0;
        bus.cmd_index = '0;
        bus.cmd_argument = '0;
        bus.phys_ack_out = 1'b0;
        bus.phys_strobe_out = 1'b0;
        bus.phys_response = '0;
        bus.phys_timeout = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("post_reset");

        resp = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
        resp[47:40] = 8'h11;
        run_cmd("short_ok", 6'd17, 32'h0000_0200, 0, 0, 0, 3, 2, resp, 0);
        chk("short_ok_word", bus.cmd_to_send, 40'h51_0000_0200);

        resp = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
        resp[47:40] = 8'hff;
        run_cmd("long_r2", 6'd2, $urandom, 0, 0, 0, 1, 4, resp, 0);
        run_cmd("all_timeout", 6'd17, $urandom, 5, 0, 0, 0, 3, resp, 0);
        run_cmd("no_ack", 6'd8, $urandom, 0, 1, 0, 0, 0, resp, 0);

        resp = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
        resp[47:40] = {2'b00, 6'd18};
        run_cmd("both_same_cycle", 6'd17, $urandom, 0, 0, 1, 2, 1, resp, 0);

        resp[47:40] = {2'b00, 6'd5};
        run_cmd("busy_request", 6'd5, 32'hdead_beef, 0, 0, 0, 3, 4, resp, 1);

        for (int n = 0; n < 8; n++) begin
            idx = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) idx = longs[$urandom_range(0, 3)];
            arg = $urandom;
            resp = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
            if ($urandom_range(0, 1) == 1) resp[47:40] = {2'b00, idx};
            run_cmd($sformatf("rand%0d", n), idx, arg, $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 5), $urandom_range(0, 5), resp, 0);
        end

        @(negedge clk);
        bus.new_command = 1'b1;
        bus.cmd_index = 6'd17;
        bus.cmd_argument = 32'h1234_5678;
        @(negedge clk);
        bus.new_command = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (bus.phys_strobe) seen = 1'b1;
            else @(negedge clk);
        end
        chk("mid_reset_strobe_seen", seen, 1);
        bus.phys_ack_out = 1'b1;
        @(negedge clk);
        bus.phys_ack_out = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        completes = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.command_complete) completes++;
        end
        chk("mid_reset_no_complete", completes, 0);
        chk("mid_reset_idle", bus.phys_idle, 1);

        resp = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
        resp[47:40] = {2'b00, 6'd55};
        run_cmd("recover", 6'd55, $urandom, 1, 0, 0, 0, 0, resp, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmd_layer_controller.md
Name: cmd_layer_controller

Overview:
Host-side sequencer for the SD command physical layer.
- Accepts a command request (index + argument) from the host register file.
- Formats the 40-bit command word and drives the strobe/ack/idle handshake of the command PHY.
- Waits for the response or a timeout, validates short responses, and retries on timeout up to a limit.
- Returns the 136-bit response and a completion/error status to the host.

Parameters:
- MAX_RETRIES, 2, re-issues after a PHY timeout before declaring cmd_error
- ACK_TIMEOUT, 64, sd_clock cycles allowed between phys_strobe rising and phys_ack_out
- RETRY_W, 2, width of the retry counter (must hold MAX_RETRIES)

Ports:
- sd_clock  in  1  SD clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high reset
- new_command  in  1  single-cycle host request; sampled only in IDLE
- cmd_index  in  6  command index, captured with new_command
- cmd_argument  in  32  argument, captured with new_command
- busy  out  1  high from capture until DONE exits
- command_complete  out  1  one-cycle pulse at end of every command (success or error)
- response_out  out  136  latched response; valid when command_complete is high
- cmd_error  out  1  timeout after all retries; held until next accepted command
- response_error  out  1  short-response header mismatch; held until next accepted command
- cmd_to_send  out  40  {2'b01, idx[5:0], arg[31:0]} to the PHY
- phys_strobe  out  1  request to the PHY (PHY strobe_in)
- phys_ack  out  1  response-taken acknowledge to the PHY (PHY ack_in)
- phys_idle  out  1  idle request to the PHY (PHY idle_in)
- timeout_enable  out  1  PHY TIMEOUT_ENABLE
- phys_ack_out  in  1  PHY acknowledge of the request
- phys_strobe_out  in  1  PHY signals a response was received
- phys_response  in  136  PHY response bus
- phys_timeout  in  1  PHY COMMAND_TIMEOUT

Behaviour:
Reset values:
- All outputs 0 except phys_idle=1.
- State IDLE; retry counter and ack watchdog cleared.
- Reset mid-operation aborts immediately; no completion pulse.

Registers:
- All outputs are registered.
- Latency: new_command high at edge N → busy and phys_strobe high after edge N+1.

States:
- IDLE:
  - phys_idle=1, timeout_enable=0.
  - On new_command: latch index/argument, form cmd_to_send, clear cmd_error/response_error/retry count, go to SEND.
  - new_command while busy is ignored (no queue).
- SEND:
  - phys_strobe=1, phys_idle=0, timeout_enable=1; the ack watchdog counts.
  - On phys_ack_out: drop strobe next cycle, go to WAIT_RESP.
  - If the watchdog reaches ACK_TIMEOUT: treat as timeout (go to RETRY).
- WAIT_RESP:
  - Wait for phys_strobe_out or phys_timeout.
  - If both arrive in the same cycle, the response wins.
  - On phys_strobe_out: latch phys_response into response_out, go to ACK.
  - On phys_timeout: go to RETRY.
- ACK:
  - phys_ack=1 for exactly one cycle.
  - Validate unless index is 2, 9, 10 or 41 (R2/R3): response_out[47:46]==2'b00 and response_out[45:40]==cmd_index, otherwise set response_error.
  - Go to DONE.
- RETRY:
  - Pulse phys_idle for one cycle to reset the PHY.
  - If retry count < MAX_RETRIES: increment, return to SEND with the same cmd_to_send.
  - Otherwise: set cmd_error, clear response_out, go to DONE.
- DONE:
  - command_complete=1 for one cycle, phys_idle=1, busy drops on the following edge.
  - Return to IDLE.

Widths and counters:
- The watchdog saturates; it never wraps.
- The retry counter never exceeds MAX_RETRIES.
- response_error is only evaluated on successful receptions.

Decomposition:
- Shared package cmd_pkg:
  - state encoding (IDLE, SEND, WAIT_RESP, ACK, RETRY, DONE)
  - CMD_START_BITS = 2'b01
  - long-response index constants 2/9/10 and R3 index 41
  - RESP_W = 136, CMD_W = 40
- One natural sub-module: cmd_watchdog_counter (load/clear/enable, saturating compare to ACK_TIMEOUT), reusable for the data-line controller.

Test Plan:
1. idx=17, arg=0x0000_0200, PHY acks after 3 cycles, returns short response with [47:40]=8'h11 → cmd_to_send=40'h51_0000_0200, single phys_ack pulse, command_complete with response_out echoing the PHY bus, no errors.
2. idx=2, PHY returns 136-bit response with arbitrary header → no response_error; response_out equals phys_response exactly.
3. phys_timeout every attempt, MAX_RETRIES=2 → exactly 3 phys_strobe assertions, phys_idle pulse between them, cmd_error=1, response_out=0, one command_complete.
4. phys_ack_out never asserted → RETRY entered after 64 cycles of strobe; cmd_error after third watchdog expiry.
5. phys_strobe_out and phys_timeout in the same cycle → response accepted, no retry; idx=17 with response [45:40]=6'd18 → response_error=1.
6. Assert reset during WAIT_RESP, and new_command while busy → outputs return to reset values with phys_idle=1 and no complete pulse; the busy-time request is ignored (cmd_to_send unchanged).
